// File: rtl/fpu_sp_pkg.sv
// Shared definitions for the single-precision FPU issue front-end.
// Holds command codes, the timeout result word, FSM states and the request payload.
package fpu_sp_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [CMD_W-1:0] CMD_FPU_SP_ADD = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_FPU_SP_SUB = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_FPU_SP_MUL = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_FPU_SP_DIV = 4'b0100;

    localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } issue_state_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } fpu_op_t;

    function automatic logic cmd_legal(input logic [CMD_W-1:0] cmd);
        return cmd inside {CMD_FPU_SP_ADD, CMD_FPU_SP_SUB, CMD_FPU_SP_MUL, CMD_FPU_SP_DIV};
    endfunction

endpackage

// File: rtl/fpu_sp_issue_if.sv
// Request and response handshake bundle of the FPU issue front-end.
// master = requester/consumer side, slave = fpu_sp_issue.
interface fpu_sp_issue_if #(
    parameter int unsigned TAG_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_cmd;
    logic [31:0]       req_a;
    logic [31:0]       req_b;
    logic [TAG_W-1:0]  req_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_result;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;

    modport master (
        output req_valid, req_cmd, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err
    );

    modport slave (
        input  req_valid, req_cmd, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err
    );

endinterface

// File: rtl/fpu_sp_req_fifo.sv
// Synchronous request FIFO; DEPTH must be a power of two so pointers wrap naturally.
// can_push is registered from the next occupancy, so it reads 0 while in reset.
module fpu_sp_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 72
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       can_push,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     level_nxt_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push     = push && can_push;
    assign do_pop      = pop && !empty;
    assign empty       = (level == '0);
    assign rdata       = mem[rptr];
    assign level_nxt_c = level + LVL_W'(do_push) - LVL_W'(do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            can_push <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            level    <= level_nxt_c;
            can_push <= (level_nxt_c < LVL_W'(DEPTH));
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/fpu_sp_issue.sv
// Issues queued tagged requests one at a time to fpu_sp_top and returns results in order.
// Illegal commands are answered without touching the FPU; a hung FPU is cut off by timeout.
module fpu_sp_issue
    import fpu_sp_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    fpu_sp_issue_if.slave           bus,
    output logic [3:0]              fpu_cmd,
    output logic [31:0]             fpu_din1,
    output logic [31:0]             fpu_din2,
    output logic                    fpu_dval,
    input  logic [31:0]             fpu_result,
    input  logic                    fpu_rdy,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned OP_W  = $bits(fpu_op_t);
    localparam int unsigned ENT_W = OP_W + TAG_W;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    issue_state_e       state, state_nxt;
    fpu_op_t            op_q;
    logic [TAG_W-1:0]   tag_q;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic               rsp_valid_q;
    logic [31:0]        rsp_result_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic               rsp_err_q;
    logic               dval_q;
    logic               busy_q;

    fpu_op_t            req_op;
    fpu_op_t            head_op;
    logic [TAG_W-1:0]   head_tag;
    logic [ENT_W-1:0]   fifo_wdata;
    logic [ENT_W-1:0]   fifo_rdata;
    logic               fifo_can_push;
    logic               fifo_empty;
    logic [LVL_W-1:0]   level_nxt;

    logic               pop;
    logic               load_op;
    logic               load_rsp;
    logic [31:0]        rsp_result_d;
    logic               rsp_err_d;

    assign req_op     = '{cmd: bus.req_cmd, a: bus.req_a, b: bus.req_b};
    assign fifo_wdata = {bus.req_tag, req_op};
    assign head_op    = fpu_op_t'(fifo_rdata[OP_W-1:0]);
    assign head_tag   = fifo_rdata[ENT_W-1:OP_W];

    fpu_sp_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (bus.req_valid),
        .wdata       (fifo_wdata),
        .pop         (pop),
        .rdata       (fifo_rdata),
        .can_push    (fifo_can_push),
        .empty       (fifo_empty),
        .level       (level),
        .level_nxt_c (level_nxt)
    );

    // Next-state, FIFO pop and response capture decisions.
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        pop          = 1'b0;
        load_op      = 1'b0;
        load_rsp     = 1'b0;
        rsp_result_d = QNAN;
        rsp_err_d    = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (cmd_legal(head_op.cmd)) begin
                        load_op   = 1'b1;
                        state_nxt = ST_ISSUE;
                    end else begin
                        load_rsp     = 1'b1;
                        rsp_result_d = 32'h0000_0000;
                        state_nxt    = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                timer_nxt = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                timer_nxt = timer + TMR_W'(1);
                // rdy in the first WAIT cycle may belong to the previous op
                if (fpu_rdy && (timer != '0)) begin
                    load_rsp     = 1'b1;
                    rsp_result_d = fpu_result;
                    rsp_err_d    = 1'b0;
                    state_nxt    = ST_RESP;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    load_rsp  = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            timer        <= '0;
            op_q         <= '0;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
            dval_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            dval_q      <= (state_nxt == ST_ISSUE);
            rsp_valid_q <= (state_nxt == ST_RESP);
            busy_q      <= (state_nxt != ST_IDLE) || (level_nxt != '0);
            if (pop)     tag_q <= head_tag;
            if (load_op) op_q  <= head_op;
            if (load_rsp) begin
                rsp_result_q <= rsp_result_d;
                rsp_err_q    <= rsp_err_d;
                // illegal commands respond straight from IDLE, before tag_q updates
                rsp_tag_q    <= (state == ST_IDLE) ? head_tag : tag_q;
            end
        end
    end

    assign fpu_cmd        = op_q.cmd;
    assign fpu_din1       = op_q.a;
    assign fpu_din2       = op_q.b;
    assign fpu_dval       = dval_q;
    assign busy           = busy_q;

    assign bus.req_ready  = fifo_can_push;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_fpu_sp_issue.sv
// Directed bench for fpu_sp_issue with a table-driven FPU responder and an in-order scoreboard.
module tb_fpu_sp_issue;
    import fpu_sp_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned TIMEOUT = 64;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  fpu_cmd;
    logic [31:0] fpu_din1;
    logic [31:0] fpu_din2;
    logic        fpu_dval;
    logic [31:0] fpu_result;
    logic        fpu_rdy;
    logic        busy;
    logic [2:0]  level;

    fpu_sp_issue_if #(.TAG_W(TAG_W)) bus ();

    fpu_sp_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fpu_cmd    (fpu_cmd),
        .fpu_din1   (fpu_din1),
        .fpu_din2   (fpu_din2),
        .fpu_dval   (fpu_dval),
        .fpu_result (fpu_result),
        .fpu_rdy    (fpu_rdy),
        .busy       (busy),
        .level      (level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];
    int   rd = 0;
    int   acc_cyc = 0;
    int   lat = 2;
    int   late_req = 0;

    // Written only by the monitor
    logic [31:0] obs_res [64];
    logic [3:0]  obs_tag [64];
    logic        obs_err [64];
    int          obs_n = 0;
    int          dval_cnt = 0;
    int          dval_cyc = 0;
    int          rise_cyc = 0;
    logic        rsp_prev = 1'b0;

    // Written only by the FPU responder
    int          rdy_cyc = 0;

    function automatic logic [31:0] fpu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [67:0] key;
        key = {c, a, b};
        case (key)
            {4'd1, 32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
            {4'd2, 32'h4000_0000, 32'h3F80_0000}: return 32'h3F80_0000;
            {4'd3, 32'hC040_0000, 32'h4040_0000}: return 32'hC110_0000;
            {4'd4, 32'h4040_0000, 32'h4040_0000}: return 32'h3F80_0000;
            {4'd1, 32'h7F80_0000, 32'hFF80_0000}: return 32'h7FC0_0000;
            default:                               return 32'hDEAD_BEEF;
        endcase
    endfunction

    // FPU responder: rdy pulses lat cycles after dval (lat=0: never; lat=1: only in first WAIT cycle)
    initial begin
        int          cnt;
        int          late_seen;
        logic [31:0] pend;
        cnt = 0; late_seen = 0; pend = '0;
        fpu_rdy = 1'b0;
        fpu_result = '0;
        forever begin
            @(posedge clk); #1;
            fpu_rdy = 1'b0;
            if (late_req != late_seen) begin
                late_seen  = late_req;
                fpu_rdy    = 1'b1;
                fpu_result = 32'h1234_5678;
            end else if (fpu_dval) begin
                cnt  = lat;
                pend = fpu_ref(fpu_cmd, fpu_din1, fpu_din2);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    fpu_rdy    = 1'b1;
                    fpu_result = pend;
                    rdy_cyc    = cyc;
                end
            end
        end
    end

    // Output monitor, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (fpu_dval) begin
                dval_cnt++;
                dval_cyc = cyc;
            end
            if (bus.rsp_valid && !rsp_prev) rise_cyc = cyc;
            rsp_prev = bus.rsp_valid;
            if (bus.rsp_valid && bus.rsp_ready && obs_n < 64) begin
                obs_res[obs_n] = bus.rsp_result;
                obs_tag[obs_n] = bus.rsp_tag;
                obs_err[obs_n] = bus.rsp_err;
                obs_n++;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    endtask

    task automatic check_rsps();
        exp_t e;
        while (rd < obs_n) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected_tag", 64'(obs_tag[rd]), 64'hFFFF);
            end else begin
                e = sb.pop_front();
                chk("rsp_result", 64'(obs_res[rd]), 64'(e.res));
                chk("rsp_tag",    64'(obs_tag[rd]), 64'(e.tag));
                chk("rsp_err",    64'(obs_err[rd]), 64'(e.err));
            end
            rd++;
        end
    endtask

    // Called and returns just after a rising edge
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input logic [31:0] er, input logic ee);
        int   n;
        exp_t e;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_cmd   = c;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = t;
        @(negedge clk);
        while (!bus.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("send_accept_timeout", 64'(n), 64'(0));
        end else begin
            acc_cyc = cyc;
            e.res = er; e.tag = t; e.err = ee;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || bus.rsp_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 64'(n < 1000), 64'(1));
        @(posedge clk); #1;
        check_rsps();
    endtask

    initial begin
        int   d0;
        int   n0;
        int   n;
        logic ok;

        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_cmd = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_tag = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 64'({bus.req_ready, bus.rsp_valid, fpu_dval, busy, level}), 64'(0));
        chk("reset_fpu_bus", 64'({fpu_cmd, fpu_din1}), 64'(0));
        chk("reset_rsp", 64'({bus.rsp_result, bus.rsp_tag, bus.rsp_err}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 64'(bus.req_ready), 64'(1));
        bus.rsp_ready = 1'b1;

        // Single ADD and its latencies
        d0 = dval_cnt;
        send(4'd1, 32'h3F80_0000, 32'h4000_0000, 4'd5, 32'h4040_0000, 1'b0);
        wait_idle();
        chk("add_dval_pulses", 64'(dval_cnt - d0), 64'(1));
        chk("add_issue_latency", 64'(dval_cyc - acc_cyc), 64'(2));
        chk("add_rsp_latency", 64'(rise_cyc - rdy_cyc), 64'(1));

        // Back-to-back burst
        lat = 3;
        d0 = dval_cnt;
        send(4'd2, 32'h4000_0000, 32'h3F80_0000, 4'd6, 32'h3F80_0000, 1'b0);
        send(4'd3, 32'hC040_0000, 32'h4040_0000, 4'd7, 32'hC110_0000, 1'b0);
        send(4'd4, 32'h4040_0000, 32'h4040_0000, 4'd8, 32'h3F80_0000, 1'b0);
        send(4'd1, 32'h7F80_0000, 32'hFF80_0000, 4'd9, 32'h7FC0_0000, 1'b0);
        wait_idle();
        chk("burst_dval_pulses", 64'(dval_cnt - d0), 64'(4));

        // Response backpressure while the FIFO fills
        lat = 2;
        bus.rsp_ready = 1'b0;
        send(4'd1, 32'h3F80_0000, 32'h4000_0000, 4'd1, 32'h4040_0000, 1'b0);
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_rsp_seen", 64'(bus.rsp_valid), 64'(1));
        d0 = dval_cnt;
        send(4'd2, 32'h4000_0000, 32'h3F80_0000, 4'd2, 32'h3F80_0000, 1'b0);
        send(4'd3, 32'hC040_0000, 32'h4040_0000, 4'd3, 32'hC110_0000, 1'b0);
        send(4'd4, 32'h4040_0000, 32'h4040_0000, 4'd4, 32'h3F80_0000, 1'b0);
        send(4'd1, 32'h3F80_0000, 32'h4000_0000, 4'd5, 32'h4040_0000, 1'b0);
        chk("bp_full_level", 64'(level), 64'(4));
        chk("bp_full_ready", 64'(bus.req_ready), 64'(0));
        bus.req_valid = 1'b1;
        bus.req_cmd = 4'd1;
        bus.req_tag = 4'd15;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            ok &= bus.rsp_valid && (bus.rsp_result == 32'h4040_0000) && (bus.rsp_tag == 4'd1)
                  && !bus.rsp_err && (level == 3'd4) && !bus.req_ready;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("bp_outputs_stable", 64'(ok), 64'(1));
        chk("bp_no_issue", 64'(dval_cnt - d0), 64'(0));
        bus.rsp_ready = 1'b1;
        wait_idle();
        chk("bp_drain_issues", 64'(dval_cnt - d0), 64'(4));

        // Illegal commands, then a legal one
        d0 = dval_cnt;
        send(4'hF, 32'h3F80_0000, 32'h4000_0000, 4'd3, 32'h0000_0000, 1'b1);
        send(4'h5, 32'h3F80_0000, 32'h4000_0000, 4'd10, 32'h0000_0000, 1'b1);
        wait_idle();
        chk("illegal_no_issue", 64'(dval_cnt - d0), 64'(0));
        d0 = dval_cnt;
        send(4'd3, 32'hC040_0000, 32'h4040_0000, 4'd4, 32'hC110_0000, 1'b0);
        wait_idle();
        chk("legal_after_illegal", 64'(dval_cnt - d0), 64'(1));

        // Timeout: only a stale-window rdy is produced
        lat = 1;
        d0 = dval_cnt;
        send(4'd1, 32'h3F80_0000, 32'h4000_0000, 4'd2, QNAN, 1'b1);
        wait_idle();
        chk("timeout_latency", 64'(rise_cyc - dval_cyc), 64'(TIMEOUT + 1));
        chk("timeout_one_issue", 64'(dval_cnt - d0), 64'(1));
        n0 = obs_n;
        late_req++;
        repeat (6) @(posedge clk);
        #1;
        chk("late_rdy_no_rsp", 64'(obs_n - n0), 64'(0));
        chk("late_rdy_idle", 64'(busy), 64'(0));
        lat = 2;
        send(4'd4, 32'h4040_0000, 32'h4040_0000, 4'd6, 32'h3F80_0000, 1'b0);
        wait_idle();

        // Reset while waiting on a hung FPU with two requests queued
        lat = 0;
        send(4'd1, 32'h3F80_0000, 32'h4000_0000, 4'd7, 32'h4040_0000, 1'b0);
        send(4'd2, 32'h4000_0000, 32'h3F80_0000, 4'd8, 32'h3F80_0000, 1'b0);
        send(4'd3, 32'hC040_0000, 32'h4040_0000, 4'd9, 32'hC110_0000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pre_level", 64'(level), 64'(2));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ctrl", 64'({bus.req_ready, bus.rsp_valid, fpu_dval, busy, level}), 64'(0));
        chk("rst_mid_fpu_bus", 64'({fpu_cmd, fpu_din1}), 64'(0));
        chk("rst_mid_rsp", 64'({bus.rsp_result, bus.rsp_tag, bus.rsp_err}), 64'(0));
        rst = 1'b0;
        sb.delete();
        rd = obs_n;
        n0 = obs_n;
        d0 = dval_cnt;
        late_req++;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_late_rdy_no_rsp", 64'(obs_n - n0), 64'(0));
        chk("rst_late_rdy_no_issue", 64'(dval_cnt - d0), 64'(0));
        chk("rst_idle", 64'({busy, level}), 64'(0));

        // Recovery after reset
        lat = 2;
        send(4'd1, 32'h7F80_0000, 32'hFF80_0000, 4'd11, 32'h7FC0_0000, 1'b0);
        wait_idle();
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fpu_sp_issue.md
Name: fpu_sp_issue

Overview:
Request front-end that sits directly upstream of fpu_sp_top and feeds it. Buffers tagged operation requests in a small FIFO and issues them one at a time on fpu_sp_top's cmd/din1/din2/dval interface. Waits for rdy, captures result, and returns it with its tag on a valid/ready response port. Rejects illegal commands and recovers from a hung FPU by timeout.

Parameters:
DEPTH, 4, request FIFO entries (power of two, >=2)
TAG_W, 4, width of the request tag carried to the response
TIMEOUT, 64, max cycles in WAIT before a timeout response is forced

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request offered
req_ready  out  1  FIFO not full; request accepted when req_valid&&req_ready
req_cmd  in  4  operation code
req_a  in  32  operand 1 (IEEE-754 single)
req_b  in  32  operand 2
req_tag  in  TAG_W  caller tag
fpu_cmd  out  4  to fpu_sp_top cmd
fpu_din1  out  32  to fpu_sp_top din1
fpu_din2  out  32  to fpu_sp_top din2
fpu_dval  out  1  one-cycle issue strobe
fpu_result  in  32  from fpu_sp_top result
fpu_rdy  in  1  from fpu_sp_top rdy
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_result  out  32  result word
rsp_tag  out  TAG_W  tag of the originating request
rsp_err  out  1  1 = illegal cmd or timeout
busy  out  1  FSM not in IDLE or FIFO non-empty
level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: all outputs 0; FIFO emptied; FSM=IDLE; timer=0. Reset mid-operation abandons the in-flight op; any late fpu_rdy is ignored (FSM is in IDLE).
- FIFO: push on req_valid&&req_ready; req_ready=(level<DEPTH). Simultaneous push and pop while full is not allowed (req_ready=0 when full); simultaneous push/pop otherwise keeps level unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if FIFO non-empty, pop head into an op register. Legal cmd (ADD=1, SUB=2, MUL=3, DIV=4) -> ISSUE. Any other cmd -> RESP with result 32'h0000_0000, err=1, no FPU activity.
- ISSUE: fpu_dval=1 for exactly this cycle. fpu_cmd/din1/din2 driven from the op register, held stable from ISSUE through WAIT. Timer cleared. -> WAIT.
- WAIT: fpu_rdy is ignored in the first WAIT cycle (stale rdy from the previous op). From the second cycle on, fpu_rdy=1 captures fpu_result, err=0 -> RESP. Timer increments each cycle. Timer reaching TIMEOUT with no rdy gives result 32'h7FC0_0000, err=1 -> RESP.
- RESP: rsp_valid=1; rsp_result/tag/err stable until rsp_valid&&rsp_ready, then -> IDLE. Minimum spacing between issues: 1 IDLE cycle. No lookahead pop.
- Latency: a request pushed into an empty FIFO shows fpu_dval 2 cycles after acceptance. rsp_valid rises 1 cycle after qualified fpu_rdy.
- Requests are processed strictly in order; tags are returned unmodified.
- fpu_dval is 0 in every state except ISSUE.

Decomposition:
- Shared package fpu_sp_pkg: CMD_FPU_SP_ADD/SUB/MUL/DIV codes (4'b0001..4'b0100), QNAN constant 32'h7FC0_0000, FSM state enum, cmd-legality function.
- One sub-module: fpu_sp_req_fifo (parameterised synchronous FIFO, width 4+32+32+TAG_W, push/pop/full/empty/level). The FSM and timer stay in fpu_sp_issue.

Test Plan:
- Single ADD: cmd=1, a=3F800000, b=40000000, tag=5, with fpu_sp_top attached -> exactly one fpu_dval pulse; rsp_result=40400000, tag=5, err=0.
- Back-to-back burst: push DEPTH requests SUB(40000000,3F800000), MUL(C0400000,40400000), DIV(40400000,40400000), ADD(7F800000,FF800000) with rsp_ready=1 -> req_ready=0 while level=4; in-order responses 3F800000, C1100000, 3F800000, 7FC00000; tags preserved.
- Response backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> outputs stable, no new fpu_dval, FIFO keeps accepting until full.
- Illegal cmd=4'b1111 with tag=3 -> no fpu_dval; rsp_result=00000000, err=1, tag=3; the following legal request issues normally.
- Timeout: FPU model never asserts rdy -> rsp after TIMEOUT cycles in WAIT with result 7FC00000, err=1. A late fpu_rdy pulse then has no effect.
- Reset mid-op: assert rst during WAIT with 2 entries queued -> next cycle all outputs 0, level=0, busy=0; a subsequent fpu_rdy produces no response.
